framebuffer_arbiter: RTL and testbench



---
 rtl/framebuffer_arbiter.sv | 146 ++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// Double-buffered pixel RAM arbiter: driver reads (2-cycle latency, never stalled) beat clear writes beat host writes; swaps wait for frame end.
// Host sees wr_ready=0 while reading, swap pending or clearing. Optional CLEAR_ON_SWAP_EN zeroes the new back buffer after each swap.
module framebuffer_arbiter #(
   parameter  int rows       = 8,
   parameter  int columns    = 32,
   parameter  int pixelwidth = 24,
   localparam int RB         = $clog2(rows),
   localparam int CB         = $clog2(columns),
   localparam int AW         = 1 + RB + CB
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  drv_rd,
   input  logic [RB-1:0]         drv_row,
   input  logic [CB-1:0]         drv_col,
   output logic [pixelwidth-1:0] drv_pixel,
   output logic                  drv_pixel_valid,
   input  logic                  drv_frame_complete,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [RB-1:0]         wr_row,
   input  logic [CB-1:0]         wr_col,
   input  logic [pixelwidth-1:0] wr_data,
   input  logic                  swap_req,
   output logic                  swap_pending,
   output logic                  front_sel,
   output logic                  clear_busy,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_we,
   output logic [pixelwidth-1:0] mem_wdata,
   input  logic [pixelwidth-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_CLEAR} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_front;
   logic                  r_rd_d1;
   logic [pixelwidth-1:0] r_pixel;
   logic                  r_pixel_vld;
   logic                  w_wr_ready;
   logic                  w_wr_xfer;
   logic                  w_swap;
   logic                  w_clr_last;

   assign w_swap     = (r_state == S_PENDING) && drv_frame_complete;
   assign w_wr_ready = !rst && !drv_rd && (r_state == S_IDLE);
   assign w_wr_xfer  = wr_valid && w_wr_ready;

`ifdef CLEAR_ON_SWAP_EN
   localparam logic [RB-1:0] LAST_ROW = RB'(rows - 1);
   localparam logic [CB-1:0] LAST_COL = CB'(columns - 1);

   logic [RB-1:0] r_clr_row;
   logic [CB-1:0] r_clr_col;
   logic          w_clr_we;

   // Clear only advances in cycles the driver leaves the RAM free.
   assign w_clr_we   = (r_state == S_CLEAR) && !drv_rd;
   assign w_clr_last = w_clr_we && (r_clr_row == LAST_ROW) && (r_clr_col == LAST_COL);

   always_ff @(posedge clk) begin
      if (rst || (r_state != S_CLEAR)) begin
         r_clr_row <= '0;
         r_clr_col <= '0;
      end else if (w_clr_we) begin
         if (r_clr_col == LAST_COL) begin
            r_clr_col <= '0;
            r_clr_row <= r_clr_row + RB'(1);
         end else begin
            r_clr_col <= r_clr_col + CB'(1);
         end
      end
   end
`else
   assign w_clr_last = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (swap_req) w_state_nxt = S_PENDING;
         S_PENDING: if (drv_frame_complete) begin
`ifdef CLEAR_ON_SWAP_EN
            w_state_nxt = S_CLEAR;
`else
            w_state_nxt = S_IDLE;
`endif
         end
         S_CLEAR:   if (w_clr_last) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_front <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_swap) r_front <= ~r_front;
      end
   end

   // RAM data lands one cycle after the address, so capture it one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_d1     <= 1'b0;
         r_pixel     <= '0;
         r_pixel_vld <= 1'b0;
      end else begin
         r_rd_d1     <= drv_rd;
         r_pixel_vld <= r_rd_d1;
         if (r_rd_d1) r_pixel <= mem_rdata;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (drv_rd) begin
         mem_addr = {r_front, drv_row, drv_col};
      end
`ifdef CLEAR_ON_SWAP_EN
      else if (w_clr_we) begin
         mem_we   = !rst;
         mem_addr = {~r_front, r_clr_row, r_clr_col};
      end
`endif
      else if (w_wr_xfer) begin
         mem_we    = 1'b1;
         mem_addr  = {~r_front, wr_row, wr_col};
         mem_wdata = wr_data;
      end
   end

   assign wr_ready        = w_wr_ready;
   assign drv_pixel       = r_pixel;
   assign drv_pixel_valid = r_pixel_vld;
   assign swap_pending    = (r_state == S_PENDING);
   assign clear_busy      = (r_state == S_CLEAR);
   assign front_sel       = r_front;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed scenarios plus a randomized run checked against a frame-level model.
// Works with and without CLEAR_ON_SWAP_EN.
module tb_framebuffer_arbiter;
   localparam int ROWS = 8, COLS = 32, PW = 24, RB = 3, CB = 5, AW = 9, NW = 512;

   logic          clk = 1'b0;
   logic          rst, drv_rd, drv_frame_complete, wr_valid, swap_req;
   logic [RB-1:0] drv_row, wr_row;
   logic [CB-1:0] drv_col, wr_col;
   logic [PW-1:0] wr_data, drv_pixel, mem_wdata, mem_rdata;
   logic          drv_pixel_valid, wr_ready, swap_pending, front_sel, clear_busy, mem_we;
   logic [AW-1:0] mem_addr;

   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [PW-1:0] pre_dat;
   logic [PW-1:0] ram [0:NW-1];

   always #5 clk = ~clk;

   framebuffer_arbiter #(.rows(ROWS), .columns(COLS), .pixelwidth(PW)) dut (
      .clk(clk), .rst(rst), .drv_rd(drv_rd), .drv_row(drv_row), .drv_col(drv_col),
      .drv_pixel(drv_pixel), .drv_pixel_valid(drv_pixel_valid),
      .drv_frame_complete(drv_frame_complete), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .swap_req(swap_req),
      .swap_pending(swap_pending), .front_sel(front_sel), .clear_busy(clear_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_dat;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Reference model: frame buffers as a flat array, swap state as flags, read results as a 2-deep history.
   bit            m_front, m_pending, m_clr;
   int            m_clr_idx;
   logic [PW-1:0] sh [0:NW-1];
   bit            h_v [0:1];
   logic [PW-1:0] h_d [0:1];
   logic [PW-1:0] m_last_pix;
   bit            e_ready, e_we, e_valid;
   int            e_addr;
   logic [PW-1:0] e_wdata, e_pix;
   int            n_tests = 0, n_fail = 0;

   function automatic int fb_addr(bit b, int r, int c);
      return (b ? (1 << (RB + CB)) : 0) + r * (1 << CB) + c;
   endfunction

   function automatic void model_eval();
      e_valid = h_v[1];
      e_pix   = h_v[1] ? h_d[1] : m_last_pix;
      e_ready = 0; e_we = 0; e_addr = 0; e_wdata = '0;
      if (rst) return;
      e_ready = !drv_rd && !m_pending && !m_clr;
      if (drv_rd) e_addr = fb_addr(m_front, int'(drv_row), int'(drv_col));
      else if (m_clr) begin
         e_we = 1; e_addr = fb_addr(!m_front, m_clr_idx / COLS, m_clr_idx % COLS);
      end else if (wr_valid && e_ready) begin
         e_we = 1; e_addr = fb_addr(!m_front, int'(wr_row), int'(wr_col)); e_wdata = wr_data;
      end
   endfunction

   function automatic void model_commit();
      if (rst) begin
         m_front = 0; m_pending = 0; m_clr = 0; m_clr_idx = 0;
         h_v[0] = 0; h_v[1] = 0; m_last_pix = '0;
         return;
      end
      m_last_pix = e_pix;
      h_v[1] = h_v[0]; h_d[1] = h_d[0];
      h_v[0] = drv_rd; h_d[0] = drv_rd ? sh[e_addr] : '0;
      if (e_we) sh[e_addr] = e_wdata;
      if (m_clr) begin
         if (e_we) begin
            m_clr_idx++;
            if (m_clr_idx == ROWS * COLS) m_clr = 0;
         end
      end else if (m_pending) begin
         if (drv_frame_complete) begin
            m_front = !m_front; m_pending = 0;
`ifdef CLEAR_ON_SWAP_EN
            m_clr = 1; m_clr_idx = 0;
`endif
         end
      end else if (swap_req) m_pending = 1;
   endfunction

   task automatic tick();
      model_eval(); model_commit();
      @(posedge clk); #1;
   endtask

   task automatic set_idle();
      drv_rd = 0; drv_row = '0; drv_col = '0; drv_frame_complete = 0; wr_valid = 0;
      wr_row = '0; wr_col = '0; wr_data = '0; swap_req = 0; pre_we = 0; pre_addr = '0; pre_dat = '0;
   endtask

   task automatic drain_clear();
      for (int i = 0; i < 400 && m_clr; i++) tick();
   endtask

   task automatic test_reset();
      set_idle(); rst = 1;
      for (int i = 0; i < NW; i++) begin
         pre_we = 1; pre_addr = AW'(i);
         pre_dat = (i == 'h045) ? 24'h123456 : PW'($urandom);
         sh[i] = pre_dat;
         tick();
      end
      pre_we = 0; wr_valid = 1; #1;
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      tick();
      rst = 0; wr_valid = 0; #1;
      n_tests++; if (drv_pixel !== '0 || drv_pixel_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_pixel: got %h/%b want 0/0", drv_pixel, drv_pixel_valid); end
      n_tests++; if (swap_pending !== 1'b0 || front_sel !== 1'b0 || clear_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: pend/front/clr got %b%b%b want 000", swap_pending, front_sel, clear_busy); end
      tick();
   endtask

   task automatic test_read();
      drv_rd = 1; drv_row = 3'd2; drv_col = 5'd5; #1;
      n_tests++; if (mem_addr !== 9'h045 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL read_addr: got %h we=%b want 045 we=0", mem_addr, mem_we); end
      tick();
      drv_rd = 0; #1;
      n_tests++; if (drv_pixel_valid !== 1'b0) begin n_fail++; $display("FAIL read_early_valid: got %b want 0", drv_pixel_valid); end
      tick();
      n_tests++; if (drv_pixel !== 24'h123456 || drv_pixel_valid !== 1'b1) begin
         n_fail++; $display("FAIL read_data: got %h/%b want 123456/1", drv_pixel, drv_pixel_valid); end
      tick();
      n_tests++; if (drv_pixel !== 24'h123456 || drv_pixel_valid !== 1'b0) begin
         n_fail++; $display("FAIL read_hold: got %h/%b want 123456/0", drv_pixel, drv_pixel_valid); end
   endtask

   task automatic test_write();
      wr_valid = 1; wr_row = 3'd7; wr_col = 5'd31; wr_data = 24'hFFFFFF; #1;
      n_tests++; if (wr_ready !== 1'b1 || mem_we !== 1'b1) begin
         n_fail++; $display("FAIL write_hs: ready=%b we=%b want 1/1", wr_ready, mem_we); end
      n_tests++; if (mem_addr !== 9'h1FF || mem_wdata !== 24'hFFFFFF) begin
         n_fail++; $display("FAIL write_bus: got %h/%h want 1FF/FFFFFF", mem_addr, mem_wdata); end
      tick();
      wr_valid = 0;
   endtask

   task automatic test_back_to_back();
      wr_row = 3'd3; wr_col = 5'd9; wr_data = 24'hA5A5A5;
      for (int i = 0; i < 6; i++) begin
         drv_rd = (i < 3); drv_row = 3'(i); drv_col = 5'(i + 1); wr_valid = (i <= 3); #1;
         model_eval();
         n_tests++; if (wr_ready !== (i >= 3)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, wr_ready, (i >= 3)); end
         n_tests++; if (mem_we !== (i == 3)) begin n_fail++; $display("FAIL b2b_we[%0d]: got %b want %b", i, mem_we, (i == 3)); end
         n_tests++; if (drv_pixel_valid !== (i >= 2 && i <= 4)) begin
            n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, drv_pixel_valid, (i >= 2 && i <= 4)); end
         if (i >= 2 && i <= 4) begin
            n_tests++; if (drv_pixel !== e_pix) begin n_fail++; $display("FAIL b2b_pixel[%0d]: got %h want %h", i, drv_pixel, e_pix); end
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_swap();
      swap_req = 1; #1; tick();
      swap_req = 0; wr_valid = 1; wr_data = 24'h00BEEF;
      for (int i = 1; i <= 100; i++) begin
         swap_req = (i == 50); drv_frame_complete = (i == 100); #1;
         n_tests++; if (swap_pending !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0 || front_sel !== 1'b0) begin
            n_fail++; $display("FAIL swap_wait[%0d]: pend=%b ready=%b we=%b front=%b want 1/0/0/0", i, swap_pending, wr_ready, mem_we, front_sel); end
         tick();
      end
      set_idle(); #1;
      n_tests++; if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
         n_fail++; $display("FAIL swap_toggle: front=%b pend=%b want 1/0", front_sel, swap_pending); end
`ifdef CLEAR_ON_SWAP_EN
      n_tests++; if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL swap_clear_start: got %b want 1", clear_busy); end
`else
      n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL swap_ready_back: got %b want 1", wr_ready); end
`endif
      drain_clear();
      drv_frame_complete = 1; #1; tick();
      drv_frame_complete = 0; #1;
      n_tests++; if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
         n_fail++; $display("FAIL swap_no_requeue: front=%b pend=%b want 1/0", front_sel, swap_pending); end
   endtask

   task automatic test_same_cycle();
      swap_req = 1; drv_frame_complete = 1; #1; tick();
      set_idle(); #1;
      n_tests++; if (front_sel !== 1'b1 || swap_pending !== 1'b1) begin
         n_fail++; $display("FAIL same_cycle_hold: front=%b pend=%b want 1/1", front_sel, swap_pending); end
      for (int i = 0; i < 5; i++) tick();
      drv_frame_complete = 1; #1; tick();
      drv_frame_complete = 0; #1;
      n_tests++; if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
         n_fail++; $display("FAIL same_cycle_toggle: front=%b pend=%b want 0/0", front_sel, swap_pending); end
      drain_clear();
   endtask

`ifdef CLEAR_ON_SWAP_EN
   task automatic test_clear();
      rst = 1; #1; tick(); rst = 0;
      swap_req = 1; #1; tick(); swap_req = 0;
      drv_frame_complete = 1; #1; tick(); drv_frame_complete = 0;
      wr_valid = 1; wr_data = 24'h777777;
      for (int i = 0; i < 256; i++) begin
         #1;
         n_tests++; if (clear_busy !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0) begin
            n_fail++; $display("FAIL clear_walk[%0d]: busy=%b ready=%b we=%b addr=%h data=%h want 1/0/1/%h/0", i, clear_busy, wr_ready, mem_we, mem_addr, mem_wdata, AW'(i)); end
         tick();
      end
      #1;
      n_tests++; if (clear_busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++; $display("FAIL clear_done: busy=%b ready=%b want 0/1", clear_busy, wr_ready); end
      set_idle();
      swap_req = 1; #1; tick(); swap_req = 0;
      drv_frame_complete = 1; #1; tick(); drv_frame_complete = 0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1; #1; tick(); rst = 0; #1;
      n_tests++; if (clear_busy !== 1'b0 || front_sel !== 1'b0) begin
         n_fail++; $display("FAIL clear_reset: busy=%b front=%b want 0/0", clear_busy, front_sel); end
   endtask
`endif

   task automatic test_random();
      bit hold = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst = ($urandom_range(0, 499) == 0);
         drv_rd = 1'($urandom_range(0, 1)); drv_row = 3'($urandom); drv_col = 5'($urandom);
         if (!hold) begin
            wr_valid = ($urandom_range(0, 2) != 0); wr_row = 3'($urandom); wr_col = 5'($urandom); wr_data = PW'($urandom);
         end
         swap_req = ($urandom_range(0, 39) == 0); drv_frame_complete = ($urandom_range(0, 29) == 0);
         #1;
         model_eval();
         n_tests++; if (wr_ready !== e_ready || mem_we !== e_we) begin
            n_fail++; $display("FAIL rnd_hs[%0d]: ready=%b we=%b want %b/%b", cyc, wr_ready, mem_we, e_ready, e_we); end
         if (e_we || (drv_rd && !rst)) begin
            n_tests++; if (mem_addr !== AW'(e_addr)) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", cyc, mem_addr, AW'(e_addr)); end
         end
         if (e_we) begin
            n_tests++; if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", cyc, mem_wdata, e_wdata); end
         end
         n_tests++; if (drv_pixel_valid !== e_valid || drv_pixel !== e_pix) begin
            n_fail++; $display("FAIL rnd_pixel[%0d]: got %h/%b want %h/%b", cyc, drv_pixel, drv_pixel_valid, e_pix, e_valid); end
         n_tests++; if (swap_pending !== m_pending || front_sel !== m_front || clear_busy !== m_clr) begin
            n_fail++; $display("FAIL rnd_state[%0d]: pend/front/clr got %b%b%b want %b%b%b", cyc, swap_pending, front_sel, clear_busy, m_pending, m_front, m_clr); end
         hold = wr_valid && !e_ready;
         tick();
      end
      set_idle(); rst = 0;
   endtask

   initial begin
      set_idle(); rst = 1;
      @(posedge clk); #1;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_swap();
      test_same_cycle();
`ifdef CLEAR_ON_SWAP_EN
      test_clear();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
